// File: rtl/adrv9009_rhb3_ctrl_if.sv
// adrv9009_rhb3_ctrl_if: output sample stream (Q1.15 data with valid/ready backpressure)
//   data  : FIFO head sample, meaningful while valid=1
//   valid : FIFO non-empty
//   ready : consumer accepts head when valid & ready
interface adrv9009_rhb3_ctrl_if;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/adrv9009_rhb3_ctrl.sv
// adrv9009_rhb3_ctrl: RHB3 half-band sequencer (flush/fill/run, decimate, round/saturate, output FIFO)
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_enable, i_dec_en      : start/stop filtering; decimate-by-2 select (latched in FLUSH)
//   i_in_data               : Q1.15 input sample
//   o_filt_reset, o_filt_in : drive the RHB3 instance
//   i_filt_out              : RHB3 result, Q2.30
//   o_overflow, o_state     : sticky FIFO drop flag; IDLE=0 FLUSH=1 FILL=2 RUN=3
//   out                     : output stream (master)
module adrv9009_rhb3_ctrl #(
    parameter int FILL_CYCLES = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_dec_en,
    input  logic [15:0]                 i_in_data,
    output logic                        o_filt_reset,
    output logic [15:0]                 o_filt_in,
    input  logic [31:0]                 i_filt_out,
    output logic                        o_overflow,
    output logic [1:0]                  o_state,
    adrv9009_rhb3_ctrl_if.master        out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(FILL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;
    state_t          r_state, w_next;
    logic [NW-1:0]   r_cnt;
    logic            r_dec, r_phase, r_ovf;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic [32:0]     w_round;
    logic [15:0]     w_sat;
    logic            w_keep, w_rd, w_wr;
    always_comb begin
        w_next = !i_enable ? IDLE :
                 r_state == IDLE  ? FLUSH :
                 r_state == FLUSH ? FILL :
                 (r_state == FILL && r_cnt == NW'(FILL_CYCLES - 1)) ? RUN : r_state;
        o_filt_reset = r_state == IDLE || r_state == FLUSH;
        o_filt_in    = o_filt_reset ? 16'h0 : i_in_data;
    end
    // Round half-up at bit 15, then saturate if the top three bits disagree.
    assign w_round = {i_filt_out[31], i_filt_out} + 33'd16384;
    assign w_sat   = (&w_round[32:30] || ~|w_round[32:30]) ? w_round[30:15] :
                     (w_round[32] ? 16'h8000 : 16'h7FFF);
    assign w_keep  = r_state == RUN && i_enable && (!r_dec || !r_phase);
    assign w_rd    = out.valid && out.ready;
    // A simultaneous read frees a slot, so a full FIFO still accepts the write.
    assign w_wr    = w_keep && (r_count != CW'(FIFO_DEPTH) || w_rd);
    assign out.valid  = r_count != '0;
    assign out.data   = out.valid ? r_mem[r_rptr] : 16'h0;
    assign o_overflow = r_ovf;
    assign o_state    = r_state;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_dec   <= 1'b0;
            r_ovf   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FLUSH) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_dec   <= i_dec_en;
                r_ovf   <= 1'b0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (r_state == FILL) r_cnt <= r_cnt + 1'b1;
                if (r_state == RUN) r_phase <= ~r_phase;
                if (w_keep && !w_wr) r_ovf <= 1'b1;
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (w_rd) r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= w_sat;
    end
endmodule
